// File: rtl/toy_stream_checker.sv
// toy_stream_checker
//
// Downstream consumer for the toy kernel's chunk stream. Every accepted chunk
// is expected to equal the previous chunk with each 32-bit lane decremented
// by one (wraparound). The block counts chunks and mismatching chunks per
// burst. A chunk whose low byte is zero ends the burst. One summary record
// per burst is then offered on the result interface:
//   lane 0 : chunk count (saturating)
//   lane 1 : mismatch count (saturating)
//   lane 2 : index (pre-increment chunk count) of the first bad chunk,
//            all-ones if the whole burst was clean
//   lane 3 : {30'b0, count saturated, any mismatch}
//   others : zero
//
// Build option: define TOY_CHECKER_DEBUG_LANE_MASK_EN to exclude lane 2
// from the comparison. The producer uses that lane for debug data. Lane 2 is
// still captured as part of the reference chunk.

module toy_stream_checker #(
  parameter int C_DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    in_ready,
  input  logic                    in_avail,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  input  logic                    res_ready,
  output logic                    res_avail,
  output logic [C_DATA_WIDTH-1:0] res_data
);

  localparam int          LANES    = C_DATA_WIDTH / 32;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

`ifdef TOY_CHECKER_DEBUG_LANE_MASK_EN
  // Lane 2 carries producer debug info and never follows the decrement rule.
  localparam logic [LANES-1:0] COMPARE_MASK = ~(LANES'(32'd4));
`else
  localparam logic [LANES-1:0] COMPARE_MASK = {LANES{1'b1}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Saturating 32-bit increment used by both counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    logic [31:0] result;
    if (value == ALL_ONES) begin
      result = ALL_ONES;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

  // True when any compared lane of cur_chunk differs from ref_chunk - 1.
  function automatic logic chunk_mismatch(
    input logic [C_DATA_WIDTH-1:0] ref_chunk,
    input logic [C_DATA_WIDTH-1:0] cur_chunk
  );
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (COMPARE_MASK[i] &&
          (cur_chunk[i*32 +: 32] != (ref_chunk[i*32 +: 32] - 32'd1))) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  state_t                  state_r;
  logic [C_DATA_WIDTH-1:0] prev_r;
  logic [31:0]             chunk_cnt_r;
  logic [31:0]             mism_cnt_r;
  logic [31:0]             first_bad_r;
  logic                    cnt_sat_r;
  logic                    res_avail_r;
  logic [C_DATA_WIDTH-1:0] res_data_r;

  logic                    accept_s;
  logic                    last_s;
  logic                    mismatch_s;
  logic [31:0]             nxt_chunk_cnt_s;
  logic [31:0]             nxt_mism_cnt_s;
  logic [31:0]             nxt_first_bad_s;
  logic                    nxt_cnt_sat_s;
  logic [C_DATA_WIDTH-1:0] summary_s;

  // in_ready depends only on the state register, never on res_ready.
  assign in_ready  = (state_r != ST_REPORT);
  assign res_avail = res_avail_r;
  assign res_data  = res_data_r;

  // Burst statistics as they would stand after accepting the current chunk.
  always_comb begin
    accept_s        = in_ready && in_avail;
    last_s          = (in_data[7:0] == 8'd0);
    mismatch_s      = chunk_mismatch(prev_r, in_data);
    nxt_chunk_cnt_s = chunk_cnt_r;
    nxt_mism_cnt_s  = mism_cnt_r;
    nxt_first_bad_s = first_bad_r;
    nxt_cnt_sat_s   = cnt_sat_r;
    summary_s       = '0;

    case (state_r)
      ST_IDLE: begin
        // The first chunk only establishes the reference.
        nxt_chunk_cnt_s = 32'd1;
        nxt_mism_cnt_s  = 32'd0;
        nxt_first_bad_s = ALL_ONES;
        nxt_cnt_sat_s   = 1'b0;
      end
      ST_BURST: begin
        if (mismatch_s) begin
          nxt_mism_cnt_s = sat_inc(mism_cnt_r);
          if (first_bad_r == ALL_ONES) begin
            nxt_first_bad_s = chunk_cnt_r;
          end else begin
            nxt_first_bad_s = first_bad_r;
          end
        end else begin
          nxt_mism_cnt_s  = mism_cnt_r;
          nxt_first_bad_s = first_bad_r;
        end
        nxt_chunk_cnt_s = sat_inc(chunk_cnt_r);
        nxt_cnt_sat_s   = cnt_sat_r | (chunk_cnt_r == ALL_ONES);
      end
      default: begin
        nxt_chunk_cnt_s = chunk_cnt_r;
        nxt_mism_cnt_s  = mism_cnt_r;
        nxt_first_bad_s = first_bad_r;
        nxt_cnt_sat_s   = cnt_sat_r;
      end
    endcase

    summary_s[31:0]   = nxt_chunk_cnt_s;
    summary_s[63:32]  = nxt_mism_cnt_s;
    summary_s[95:64]  = nxt_first_bad_s;
    summary_s[127:96] = {30'd0, nxt_cnt_sat_s, (nxt_mism_cnt_s != 32'd0)};
  end

  // Burst state machine with registered summary outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      prev_r      <= '0;
      chunk_cnt_r <= 32'd0;
      mism_cnt_r  <= 32'd0;
      first_bad_r <= ALL_ONES;
      cnt_sat_r   <= 1'b0;
      res_avail_r <= 1'b0;
      res_data_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_BURST: begin
          if (accept_s) begin
            // The actual data always becomes the new reference, so a single
            // bad chunk is never counted twice.
            prev_r      <= in_data;
            chunk_cnt_r <= nxt_chunk_cnt_s;
            mism_cnt_r  <= nxt_mism_cnt_s;
            first_bad_r <= nxt_first_bad_s;
            cnt_sat_r   <= nxt_cnt_sat_s;
            if (last_s) begin
              state_r     <= ST_REPORT;
              res_avail_r <= 1'b1;
              res_data_r  <= summary_s;
            end else begin
              state_r     <= ST_BURST;
              res_avail_r <= 1'b0;
              res_data_r  <= '0;
            end
          end else begin
            state_r     <= state_r;
            res_avail_r <= 1'b0;
            res_data_r  <= '0;
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            state_r     <= ST_IDLE;
            res_avail_r <= 1'b0;
            res_data_r  <= '0;
          end else begin
            state_r     <= ST_REPORT;
            res_avail_r <= 1'b1;
            res_data_r  <= res_data_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          res_avail_r <= 1'b0;
          res_data_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/toy_stream_checker.md
# toy_stream_checker

Downstream consumer for the toy kernel's chunk stream. It accepts bursts of 512-bit chunks over a ready/avail handshake, where each chunk should equal the previous chunk with every 32-bit lane decremented by 1. It checks every chunk against that rule, counts chunks and mismatches, and emits one summary record per burst on a second ready/avail interface. It sits between the kernel output and the host response path, and serves as both a self-check and a loopback reporter.

## Interface
- C_DATA_WIDTH, 512, width of chunk and result data; multiple of 32; LANES = C_DATA_WIDTH/32 (minimum 4).
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_ready  out  C_DATA_WIDTH? no: 1  checker can accept a chunk.
- in_avail  in  1  chunk valid from producer.
- in_data  in  C_DATA_WIDTH  chunk; lane i = in_data[i*32 +: 32].
- res_ready  in  1  downstream accepts summary.
- res_avail  out  1  summary valid.
- res_data  out  C_DATA_WIDTH  summary record.

Correction to the in_ready line above: in_ready is 1 bit wide.

## Operation
- **Transfer rule.** A transfer occurs on a cycle with in_ready && in_avail. A result transfer occurs on a cycle with res_ready && res_avail.
- **State machine: IDLE, BURST, REPORT.**
  - IDLE: the first accepted chunk is captured as prev. chunk_cnt=1, mism_cnt=0, first_bad=32'hFFFF_FFFF. Next state is BURST, or REPORT if in_data[7:0]==0.
  - BURST: each accepted chunk is compared lane-wise against prev lane - 1 (mod 2^32).
    - On any lane mismatch: mism_cnt++. If first_bad is still all-ones, first_bad is set to the pre-increment chunk_cnt.
    - Then chunk_cnt++ and prev is set to in_data. The actual data is always the new reference, so one error never cascades.
    - An accepted chunk with in_data[7:0]==0 ends the burst; next state is REPORT.
  - REPORT: res_avail=1 and res_data is held stable until res_ready. On the result transfer, next state is IDLE.
- **in_ready.** Driven combinationally as (state != REPORT). No chunk is accepted while a report is pending.
- **Summary record (lane n of res_data).**
  - Lane 0: chunk_cnt.
  - Lane 1: mism_cnt.
  - Lane 2: first_bad.
  - Lane 3: {30'b0, cnt_sat, mism_cnt!=0}.
  - Lanes 4..LANES-1: 0.
- **Arithmetic.**
  - chunk_cnt and mism_cnt are 32-bit and saturate at 32'hFFFF_FFFF.
  - cnt_sat is a sticky flag per burst, set when chunk_cnt would exceed all-ones.
  - Lane compare uses 32-bit wraparound subtraction, so 0 - 1 = 32'hFFFF_FFFF.
- **Reset.**
  - Any cycle with reset=1 forces IDLE and clears the counters, prev and first_bad to their IDLE values.
  - A burst or pending report in progress is discarded and no summary is emitted.
  - reset takes priority over a simultaneous transfer.

## Timing
- **Reset values:** in_ready=1 (IDLE), res_avail=0, res_data=0.
- **Chunk acceptance:** 1 chunk/cycle in IDLE and BURST; there is no bubble between chunks.
- **Report latency:** the terminating chunk is accepted at cycle T; res_avail=1 at T+1, with res_data registered and valid at T+1. in_ready=0 from T+1.
- **Report hand-off:** the result transfer occurs at cycle R; at R+1 res_avail=0, in_ready=1 and the state is IDLE. The next burst's first chunk can be accepted at R+1.
- **Single-chunk burst:** if the first chunk already has low byte 0, the burst is 1 chunk and REPORT follows one cycle later.
- **No combinational paths** from res_ready to in_ready within the same cycle. in_ready depends only on the state register.
- **Output register:** res_data is loaded on entry to REPORT and zeroed on exit.

## Configuration
- Macro: TOY_CHECKER_DEBUG_LANE_MASK_EN.
  - Defined: lane 2 is excluded from the comparison. That lane carries producer debug info, not decrementing data. Lane 2 is still captured into prev.
  - Undefined: all LANES lanes are compared.

## Test plan
- **Clean burst.** Chunks with lane0 = 3, 2, 1, 0 and all other lanes 0x10, 0xF, 0xE, 0xD, driven back-to-back.
  - Expect in_ready=1 for all 4 chunks.
  - Expect res_avail one cycle after the 4th chunk, with lane0=4, lane1=0, lane2=FFFFFFFF, lane3=0.
- **Single error.** Same stimulus, but lane 5 of the 2nd chunk is 0x20.
  - Expect lane1=2: chunk 1 mismatches against prev, and chunk 2 mismatches because 0x20-1 != 0xE.
  - Expect lane2=1 and lane3=1.
- **Single-chunk burst and wrap.** One chunk with lane0=0x0000_0100 (low byte 0), lanes 1..15 = 0.
  - Expect the report at T+1 with lane0=1 and lane1=0.
  - Follow with a burst whose lanes go 0 -> FFFFFFFF; expect no mismatch.
- **Backpressure.** Hold res_ready=0 for 10 cycles during REPORT, with in_avail=1.
  - Expect res_data stable, in_ready=0 and no chunk consumed.
  - Raise res_ready; the next chunk is accepted the following cycle.
- **Reset mid-burst.** Assert reset after 2 chunks of a 4-chunk burst.
  - Expect in_ready=1 and res_avail=0.
  - A new clean 3-chunk burst then reports lane0=3, lane1=0.
- **Macro.** Lane 2 deviates on every chunk of a clean 3-chunk burst.
  - With TOY_CHECKER_DEBUG_LANE_MASK_EN: lane1=0.
  - Without it: lane1=2 and lane2=1.
